mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single memory_driver request/read-data port between NB_REQ requesters
//   (bst_engine, tree scrubber, CSR debug access).
// - Round-robin grant on requests; in-order read-data return to the issuing requester.
// - Sits between the requesters and memory_driver (mem_* interface).
// PARAMETERS
// - NB_REQ          2    number of requesters, 2..8; index 0 = bst_engine
// - RAM_ADDR_WIDTH  16   mem_addr width
// - RAM_DATA_WIDTH  128  write/read data width
// - MAX_OUTSTANDING 4    max reads in flight (order FIFO depth); power of 2, >=2
// PORTS
// - aclk           in   1                       clock; all logic on its rising edge
// - srst           in   1                       synchronous reset, active-high
// - req_valid      in   NB_REQ                  per-requester request valid
// - req_ready      out  NB_REQ                  per-requester request accepted
// - req_rd         in   NB_REQ                  read command
// - req_wr         in   NB_REQ                  write command
// - req_addr       in   NB_REQ*RAM_ADDR_WIDTH   packed; slice i = requester i
// - req_wr_data    in   NB_REQ*RAM_DATA_WIDTH   packed; slice i = requester i
// - rsp_valid      out  NB_REQ                  read data valid for requester i
// - rsp_ready      in   NB_REQ                  read data accepted by requester i
// - rsp_data       out  RAM_DATA_WIDTH          shared read data; = mem_rd_data
// - mem_valid/mem_ready/mem_rd/mem_wr/mem_addr/mem_wr_data  out/in/out/out/out/out  to memory_driver
// - mem_rd_valid   in   1                       read data valid from memory_driver
// - mem_rd_ready   out  1                       read data ready to memory_driver
// - mem_rd_data    in   RAM_DATA_WIDTH          read data from memory_driver
// - rd_outstanding out  $clog2(MAX_OUTSTANDING)+1  reads in flight
// - err_unexp_rd   out  1                       sticky: mem_rd_valid with no read in flight
// BEHAVIOUR
// - Reset: FSM=IDLE, grant=0, rr pointer=0, FIFO empty; all outputs 0.
// - FSM IDLE: eligible[i] = req_valid[i] & ~(req_rd[i] & fifo_full). If any eligible, pick the
//   first eligible index at or after rr_ptr (cyclic), register it as owner, go to GRANT.
// - FSM GRANT: mem_valid = req_valid[owner]; mem_rd/mem_wr/mem_addr/mem_wr_data = owner's slice;
//   req_ready[owner] = mem_ready; other req_ready = 0.
//   On mem_valid & mem_ready: rr_ptr = owner+1 (wraps at NB_REQ -> 0); go to IDLE.
// - Latency: request at cycle N (IDLE) -> mem_valid at N+1; at most one command per 2 cycles.
// - Requesters hold valid/payload stable until ready. If req_valid[owner] drops in GRANT
//   (protocol violation), return to IDLE; rr_ptr unchanged.
// - Commands are forwarded unchanged; rd/wr encoding belongs to memory_driver.
// - Order FIFO: push owner index when a command with mem_rd=1 handshakes.
//   Pop on mem_rd_valid & mem_rd_ready.
// - Read return: FIFO non-empty -> rsp_valid[head] = mem_rd_valid, mem_rd_ready = rsp_ready[head];
//   other rsp_valid = 0.
// - FIFO empty -> rsp_valid = 0 and mem_rd_ready = 0. A mem_rd_valid in this state sets
//   err_unexp_rd, which stays set until srst.
// - Push and pop in the same cycle: count unchanged, both pointers advance.
// - FIFO full: read requests are ineligible; write requests still granted.
// - rd_outstanding = FIFO count; range 0..MAX_OUTSTANDING.
// - srst mid-transfer: in-flight grant and FIFO contents are discarded. The memory_driver must be
//   reset in the same cycle.
// TESTING
// - Only req 0 write, mem_ready=1: mem_valid rises 1 cycle later; req_ready[0] pulses; rr_ptr=1.
// - req 0 and req 1 valid continuously (writes, mem_ready=1): grants 0,1,0,1; one grant per 2 cycles.
// - req 1 read A=0x10, then req 0 read A=0x20; memory returns D1 then D0.
//   D1 -> rsp_valid[1] only; D0 -> rsp_valid[0] only.
// - 4 reads with no return: rd_outstanding=4; 5th read stalls, a concurrent write is granted.
//   Return one datum -> 5th read granted.
// - mem_ready held 0 for 5 cycles: mem_addr/mem_wr_data stable, req_ready=0, grant does not move.
// - mem_rd_valid=1 with FIFO empty: mem_rd_ready=0, err_unexp_rd=1 until srst.
//   srst in GRANT -> mem_valid=0 next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory_driver port among NB_REQ requesters
// Read data is routed back in issue order through a small FIFO of owner indices.
module mem_arbiter #(
  parameter int NB_REQ          = 2,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int RAM_DATA_WIDTH  = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                aclk,
  input  logic                                srst,
  input  logic [NB_REQ-1:0]                   req_valid,
  output logic [NB_REQ-1:0]                   req_ready,
  input  logic [NB_REQ-1:0]                   req_rd,
  input  logic [NB_REQ-1:0]                   req_wr,
  input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NB_REQ*RAM_DATA_WIDTH-1:0]    req_wr_data,
  output logic [NB_REQ-1:0]                   rsp_valid,
  input  logic [NB_REQ-1:0]                   rsp_ready,
  output logic [RAM_DATA_WIDTH-1:0]           rsp_data,
  output logic                                mem_valid,
  input  logic                                mem_ready,
  output logic                                mem_rd,
  output logic                                mem_wr,
  output logic [RAM_ADDR_WIDTH-1:0]           mem_addr,
  output logic [RAM_DATA_WIDTH-1:0]           mem_wr_data,
  input  logic                                mem_rd_valid,
  output logic                                mem_rd_ready,
  input  logic [RAM_DATA_WIDTH-1:0]           mem_rd_data,
  output logic [$clog2(MAX_OUTSTANDING):0]    rd_outstanding,
  output logic                                err_unexp_rd
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [IDX_W-1:0]  head;
  logic              cmd_hs, push, pop;
  logic [NB_REQ-1:0] eligible;
  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand_idx;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign cmd_hs     = (state_q == ST_GRANT) & req_valid[owner_q] & mem_ready;
  assign push       = cmd_hs & req_rd[owner_q];
  assign pop        = ~fifo_empty & mem_rd_valid & rsp_ready[head];

  assign rsp_data       = mem_rd_data;
  assign rd_outstanding = count_q;
  assign err_unexp_rd   = err_q;

  always_comb begin
    mem_valid   = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    req_ready   = '0;
    if (state_q == ST_GRANT) begin
      mem_valid          = req_valid[owner_q];
      mem_rd             = req_rd[owner_q];
      mem_wr             = req_wr[owner_q];
      mem_addr           = req_addr[owner_q*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      mem_wr_data        = req_wr_data[owner_q*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
      req_ready[owner_q] = mem_ready;
    end
  end

  always_comb begin
    rsp_valid    = '0;
    mem_rd_ready = 1'b0;
    if (!fifo_empty) begin
      rsp_valid[head] = mem_rd_valid;
      mem_rd_ready    = rsp_ready[head];
    end
  end

  // A read is held off while the FIFO is full so its response always has a slot.
  always_comb begin
    eligible = req_valid & ~(req_rd & {NB_REQ{fifo_full}});
    found    = 1'b0;
    pick     = '0;
    cand_idx = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (int'(rr_ptr_q) + k >= NB_REQ) begin
        cand_idx = IDX_W'(int'(rr_ptr_q) + k - NB_REQ);
      end else begin
        cand_idx = IDX_W'(int'(rr_ptr_q) + k);
      end
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = ST_GRANT;
        end
      end
      default: begin
        if (!req_valid[owner_q]) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          rr_ptr_d = (owner_q == IDX_W'(NB_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = owner_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d   = err_q | (mem_rd_valid & fifo_empty);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
// Reference model: grant flag/owner/rr index plus a queue of issuing requesters.
module tb_mem_arbiter;

  localparam int NB = 3;
  localparam int AW = 16;
  localparam int DW = 128;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic              srst;
  logic [NB-1:0]     req_valid, req_ready, req_rd, req_wr, rsp_valid, rsp_ready;
  logic [NB*AW-1:0]  req_addr;
  logic [NB*DW-1:0]  req_wr_data;
  logic [DW-1:0]     rsp_data, mem_wr_data, mem_rd_data;
  logic              mem_valid, mem_ready, mem_rd, mem_wr, mem_rd_valid, mem_rd_ready;
  logic [AW-1:0]     mem_addr;
  logic [CW-1:0]     rd_outstanding;
  logic              err_unexp_rd;

  mem_arbiter #(
    .NB_REQ(NB), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .srst(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .rd_outstanding(rd_outstanding), .err_unexp_rd(err_unexp_rd)
  );

  // Requester-side command registers driven onto the packed ports.
  bit          rv [NB];
  bit          rrd[NB];
  bit          rwr[NB];
  logic [AW-1:0] raddr[NB];
  logic [DW-1:0] rdat [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      req_valid[i]                = rv[i];
      req_rd[i]                   = rrd[i];
      req_wr[i]                   = rwr[i];
      req_addr[i*AW +: AW]        = raddr[i];
      req_wr_data[i*DW +: DW]     = rdat[i];
    end
  end

  bit            m_granted;
  int            m_owner, m_rr;
  int            m_order[$];
  bit            m_err;
  logic [DW-1:0] mem_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_cycle();
    logic [NB-1:0] e_rdy, e_rsp;
    logic          e_mv, e_rdr;
    e_rdy = '0; e_rsp = '0; e_mv = 1'b0; e_rdr = 1'b0;
    if (m_granted) begin
      e_mv = rv[m_owner];
      e_rdy[m_owner] = mem_ready;
    end
    if (m_order.size() > 0) begin
      e_rsp[m_order[0]] = mem_rd_valid;
      e_rdr = rsp_ready[m_order[0]];
    end
    check_eq("mem_valid", DW'(mem_valid), DW'(e_mv));
    check_eq("req_ready", DW'(req_ready), DW'(e_rdy));
    check_eq("rsp_valid", DW'(rsp_valid), DW'(e_rsp));
    check_eq("mem_rd_ready", DW'(mem_rd_ready), DW'(e_rdr));
    check_eq("rd_outstanding", DW'(rd_outstanding), DW'(m_order.size()));
    check_eq("err_unexp_rd", DW'(err_unexp_rd), DW'(m_err));
    check_eq("rsp_data", rsp_data, mem_rd_data);
    if (m_granted) begin
      check_eq("mem_addr", DW'(mem_addr), DW'(raddr[m_owner]));
      check_eq("mem_wr_data", mem_wr_data, rdat[m_owner]);
      check_eq("mem_rd", DW'(mem_rd), DW'(rrd[m_owner]));
      check_eq("mem_wr", DW'(mem_wr), DW'(rwr[m_owner]));
    end
  endtask

  task automatic update_model();
    bit pop;
    int i;
    if (srst) begin
      m_granted = 1'b0; m_owner = 0; m_rr = 0; m_err = 1'b0;
      m_order.delete();
      mem_q.delete();
      return;
    end
    pop = (m_order.size() > 0) && mem_rd_valid && rsp_ready[m_order[0]];
    if (mem_rd_valid && m_order.size() == 0) m_err = 1'b1;
    if (m_granted) begin
      if (!rv[m_owner]) begin
        m_granted = 1'b0;
      end else if (mem_ready) begin
        if (rrd[m_owner]) begin
          m_order.push_back(m_owner);
          mem_q.push_back(rand_data());
        end
        m_rr = (m_owner + 1) % NB;
        m_granted = 1'b0;
        rv[m_owner] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        i = (m_rr + k) % NB;
        if (rv[i] && !(rrd[i] && m_order.size() == MO)) begin
          m_granted = 1'b1;
          m_owner = i;
          break;
        end
      end
    end
    if (pop) begin
      void'(m_order.pop_front());
      void'(mem_q.pop_front());
    end
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(posedge aclk);
    #1;
    update_model();
    @(negedge aclk);
  endtask

  task automatic drive_random(input int p_new, input int p_rd, input int p_rdy, input int p_ret,
                              input int p_rsp, input int p_drop, input int p_rst);
    for (int i = 0; i < NB; i++) begin
      if (!rv[i]) begin
        if ($urandom_range(99) < p_new) begin
          rv[i]    = 1'b1;
          rrd[i]   = ($urandom_range(99) < p_rd);
          rwr[i]   = !rrd[i];
          raddr[i] = AW'($urandom);
          rdat[i]  = rand_data();
        end
      end else if ($urandom_range(99) < p_drop) begin
        rv[i] = 1'b0;
      end
      rsp_ready[i] = ($urandom_range(99) < p_rsp);
    end
    mem_ready = ($urandom_range(99) < p_rdy);
    if (mem_q.size() > 0 && $urandom_range(99) < p_ret) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = mem_q[0];
    end else begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = rand_data();
    end
    srst = ($urandom_range(99) < p_rst);
  endtask

  task automatic run_phase(input int n, input int p_new, input int p_rd, input int p_rdy,
                           input int p_ret, input int p_rsp, input int p_drop, input int p_rst);
    for (int c = 0; c < n; c++) begin
      drive_random(p_new, p_rd, p_rdy, p_ret, p_rsp, p_drop, p_rst);
      step();
    end
  endtask

  initial begin
    srst = 1'b1;
    mem_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; rsp_ready = '0;
    for (int i = 0; i < NB; i++) begin
      rv[i] = 1'b0; rrd[i] = 1'b0; rwr[i] = 1'b0; raddr[i] = '0; rdat[i] = '0;
    end
    repeat (2) @(posedge aclk);
    #1;
    update_model();
    @(negedge aclk);
    step();
    srst = 1'b0;

    run_phase(600, 50, 50, 70, 60, 70, 0, 0);
    run_phase(150, 60, 70, 90, 0, 70, 0, 0);
    run_phase(150, 40, 50, 80, 60, 80, 0, 0);
    run_phase(300, 60, 40, 20, 50, 60, 0, 0);
    run_phase(300, 50, 50, 60, 50, 60, 5, 0);
    run_phase(400, 50, 50, 70, 50, 70, 0, 2);

    // Unexpected read data, then reset while a grant is pending.
    for (int i = 0; i < NB; i++) rv[i] = 1'b0;
    mem_ready = 1'b0; rsp_ready = '1; mem_rd_valid = 1'b0; srst = 1'b1;
    step();
    srst = 1'b0;
    step();
    mem_rd_valid = 1'b1;
    mem_rd_data  = rand_data();
    step();
    mem_rd_valid = 1'b0;
    repeat (3) step();
    rv[0] = 1'b1; rrd[0] = 1'b0; rwr[0] = 1'b1; raddr[0] = 16'h0040; rdat[0] = rand_data();
    step();
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    step();
    mem_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
